pkt_framer_tx: RTL
==================

Name: pkt_framer_tx

Overview:
Transmit side of the head/data/tail packet link used by the `state`/`next_state` packet-tracking FSMs.
- Accepts a packet request (word count) and a payload word stream.
- Drives `valid`, `head`, `tail` and `dout` so that a downstream head/data/tail receiver FSM walks IDLE->HEAD->(DATA)*->TAIL->IDLE with no illegal transition.
- Enforces a minimum idle gap between packets.

Parameters:
- DATA_W, 8, payload word width.
- LEN_W, 8, width of the request length field.
- MIN_GAP, 2, minimum number of GAP-state cycles after a packet's final word handshake; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  packet request offered.
- req_ready  out  1  request accepted when both are high.
- req_len  in  LEN_W  packet length in words; legal when >= 2.
- din_valid  in  1  payload word offered.
- din_ready  out  1  payload word taken when both are high.
- din  in  DATA_W  payload word.
- valid  out  1  output beat valid (registered).
- head  out  1  first beat of packet (registered).
- tail  out  1  last beat of packet (registered).
- dout  out  DATA_W  output word (registered).
- busy  out  1  high in every state except IDLE.
- err_len  out  1  one-cycle pulse when a request is rejected for bad length.

Behaviour:
Reset:
- While reset=0, all outputs are 0 immediately (asynchronous), except req_ready, which is also 0.
- State = IDLE, counters cleared.
- A packet in flight is dropped with no tail emitted.
- The first edge after release finds IDLE, so req_ready=1 in that cycle.

States: IDLE, SEND_HEAD, SEND_BODY, GAP.

IDLE:
- req_ready=1, din_ready=0.
- Request handshake with req_len>=2: latch remaining=req_len, go to SEND_HEAD.
- Request handshake with req_len<2: request consumed, err_len=1 next cycle, stay in IDLE.

SEND_HEAD:
- din_ready=1.
- On din handshake: next cycle valid=1, head=1, tail=0, dout=din; remaining decrements; go to SEND_BODY.

SEND_BODY:
- din_ready=1.
- On din handshake: next cycle valid=1, head=0, dout=din, and tail=1 iff remaining==1 before the decrement.
- On the tail handshake: go to GAP if MIN_GAP>0, else IDLE.

GAP:
- req_ready=0, din_ready=0.
- Counts MIN_GAP cycles, then goes to IDLE.

Bubbles and output rules:
- A cycle with no din handshake produces valid=0, head=0, tail=0 on the next cycle; dout holds its value.
- Bubbles are legal anywhere inside a packet.
- head and tail are never both 1; both are 0 whenever valid=0.

Latency and gap:
- Request handshake at cycle N -> din_ready=1 at N+1.
- Word handshake at cycle M -> beat on outputs at M+1.
- Output idle cycles between a tail beat and the next head beat is at least MIN_GAP+1, assuming no stall.

Width and boundaries:
- remaining is LEN_W bits and never wraps.
- req_len = 2^LEN_W-1 produces exactly that many beats.
- req_len=2 produces a head beat then a tail beat, with no DATA beats.
- req_valid is ignored outside IDLE; req_len is sampled only at handshake.
- din is never consumed outside SEND_HEAD/SEND_BODY.

Decomposition:
- Shared package pkt_link_pkg:
  - state enum {IDLE, SEND_HEAD, SEND_BODY, GAP}, 2-bit encoding.
  - MIN_PKT_LEN=2.
  - Receiver state encoding constants (00/01/10/11) for bench reference models.
- No sub-module required. The gap counter and length counter stay inline.

Test Plan:
- Length 2, continuous payload: req_len=2, din=8'hA1 then 8'hB2 continuously.
  - Required: two consecutive valid beats, (head=1, dout=A1) then (tail=1, dout=B2).
  - Receiver model path is IDLE->HEAD->TAIL->IDLE.
- Length 5 with bubbles: req_len=5, din_valid low for 2 cycles after word 2.
  - Required: exactly 5 valid beats, head on the 1st only, tail on the 5th only.
  - 2 valid=0 cycles with head=tail=0; receiver model stays in DATA across the bubble.
- Bad lengths: req_len=0, then req_len=1.
  - Required: each request accepted (req_ready=1); err_len pulses 1 cycle each.
  - No valid beat, din_ready stays 0, state stays IDLE.
- Back-to-back packets: MIN_GAP=3, two back-to-back req_len=3 requests, payload always valid.
  - Required: exactly 4 output idle cycles between first tail and second head.
  - req_ready=0 during the 3 GAP cycles.
- Reset mid-packet: assert reset=0 asynchronously after the head beat of a req_len=6 packet.
  - Required: valid/head/tail/busy drop to 0 without a clock edge; no tail beat emitted.
  - After release: req_ready=1 and a new packet is framed correctly.
- Maximum length: LEN_W=4, req_len=15.
  - Required: 15 valid beats, tail on the 15th, no counter wrap, and busy returns to 0 after GAP.

Source files
------------

// File: rtl/pkt_link_pkg.sv
// Shared types and constants for the head/data/tail packet link.
package pkt_link_pkg;

  // Transmit framer states
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND_HEAD = 2'b01,
    SEND_BODY = 2'b10,
    GAP       = 2'b11
  } tx_state_t;

  // Shortest legal packet: one head beat plus one tail beat
  localparam int unsigned MIN_PKT_LEN = 2;

  // Width of the inter-packet gap counter (MIN_GAP range 0..15)
  localparam int unsigned GAP_CNT_W = 4;

  // Receiver-side state encodings for reference models
  localparam logic [1:0] RX_IDLE = 2'b00;
  localparam logic [1:0] RX_HEAD = 2'b01;
  localparam logic [1:0] RX_DATA = 2'b10;
  localparam logic [1:0] RX_TAIL = 2'b11;

endpackage

// File: rtl/pkt_framer_tx.sv
// Packet framer: turns a length request plus a word stream into
// head/data/tail beats, with a minimum idle gap between packets.
module pkt_framer_tx
  import pkt_link_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic              head,
  output logic              tail,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              err_len
);

  // Gap counter load value; the counter expires after MIN_GAP GAP cycles
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (MIN_GAP != 0) ? GAP_CNT_W'(MIN_GAP - 1) : '0;

  tx_state_t             state_q, state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  valid_d, head_d, tail_d, err_len_d;
  logic [DATA_W-1:0]     dout_d;

  // Handshake enables follow the state register; req_ready is also held low in reset
  assign req_ready = reset && (state_q == IDLE);
  assign din_ready = (state_q == SEND_HEAD) || (state_q == SEND_BODY);
  assign busy      = (state_q != IDLE);

  // State, counters and registered beat outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
      valid       <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
      dout        <= '0;
      err_len     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      valid       <= valid_d;
      head        <= head_d;
      tail        <= tail_d;
      dout        <= dout_d;
      err_len     <= err_len_d;
    end
  end

  // Next-state, counter and beat decode; no din handshake means a bubble
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    valid_d     = 1'b0;
    head_d      = 1'b0;
    tail_d      = 1'b0;
    dout_d      = dout;
    err_len_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_len >= LEN_W'(MIN_PKT_LEN)) begin
            remaining_d = req_len;
            state_d     = SEND_HEAD;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      SEND_HEAD: begin
        if (din_valid) begin
          valid_d     = 1'b1;
          head_d      = 1'b1;
          dout_d      = din;
          remaining_d = remaining_q - LEN_W'(1);
          state_d     = SEND_BODY;
        end
      end
      SEND_BODY: begin
        if (din_valid) begin
          valid_d     = 1'b1;
          dout_d      = din;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            tail_d = 1'b1;
            if (MIN_GAP != 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
